// File: rtl/tick_bcd_timer.sv
// ============================================================================
// tick_bcd_timer : slow_clk synchroniser, rising-edge tick, MM:SS BCD up/down timer
// Rev 1.0
// ============================================================================
`default_nettype none

module tick_bcd_timer #(
  parameter int MAX_MIN_TENS = 9,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        slow_clk,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        count_down,
  output logic [15:0] bcd_out,
  output logic        tick,
  output logic        running,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0]  MAX_MT  = 4'(MAX_MIN_TENS);
  localparam logic [15:0] CEILING = {MAX_MT, 4'd9, 4'd5, 4'd9};

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   hist;
  logic                   rise;
  logic [15:0]            inc_val;
  logic [15:0]            dec_val;

  function automatic logic [15:0] bcd_sanitise(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    mt = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
    mt = (mt > MAX_MT) ? MAX_MT : mt;
    mo = (v[11:8] > 4'd9) ? 4'd9 : v[11:8];
    st = (v[7:4]  > 4'd5) ? 4'd5 : v[7:4];
    so = (v[3:0]  > 4'd9) ? 4'd9 : v[3:0];
    return {mt, mo, st, so};
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd9) so = so + 4'd1;
    else begin
      so = 4'd0;
      if (st != 4'd5) st = st + 4'd1;
      else begin
        st = 4'd0;
        if (mo != 4'd9) mo = mo + 4'd1;
        else begin
          mo = 4'd0;
          mt = mt + 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd0) so = so - 4'd1;
    else begin
      so = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mo != 4'd0) mo = mo - 4'd1;
        else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign rise    = sync_ff[SYNC_STAGES-1] & ~hist;
  assign inc_val = bcd_inc(bcd_out);
  assign dec_val = bcd_dec(bcd_out);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_ff <= '0;
      hist    <= 1'b0;
      tick    <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], slow_clk};
      hist    <= sync_ff[SYNC_STAGES-1];
      tick    <= rise;
    end
  end

  // Controls that have no effect in the current state fall through to lower priorities.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bcd_out <= 16'h0000;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        bcd_out <= 16'h0000;
        running <= 1'b0;
      end else if (load && state != RUN) begin
        state   <= IDLE;
        bcd_out <= bcd_sanitise(load_val);
        running <= 1'b0;
      end else if (start && (state == IDLE || state == PAUSED)) begin
        if (state == IDLE && count_down && bcd_out == 16'h0000) begin
          state   <= DONE;
          done    <= 1'b1;
          running <= 1'b0;
        end else begin
          state   <= RUN;
          running <= 1'b1;
        end
      end else if (pause && state == RUN) begin
        state   <= PAUSED;
        running <= 1'b0;
      end else if (rise && state == RUN) begin
        // At a limit the value holds; otherwise step and finish if the limit is reached.
        if (count_down) begin
          if (bcd_out == 16'h0000 || dec_val == 16'h0000) begin
            state   <= DONE;
            done    <= 1'b1;
            running <= 1'b0;
          end
          if (bcd_out != 16'h0000) bcd_out <= dec_val;
        end else begin
          if (bcd_out == CEILING || inc_val == CEILING) begin
            state   <= DONE;
            done    <= 1'b1;
            running <= 1'b0;
          end
          if (bcd_out != CEILING) bcd_out <= inc_val;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tick_bcd_timer.sv
// ============================================================================
// tb_tick_bcd_timer : directed vector bench for tick_bcd_timer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tick_bcd_timer;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        slow_clk = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic        count_down = 1'b0;
  logic [15:0] bcd_out;
  logic        tick;
  logic        running;
  logic        done;

  int errors = 0;
  int checks = 0;

  tick_bcd_timer #(.MAX_MIN_TENS(9), .SYNC_STAGES(2)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .slow_clk   (slow_clk),
    .start      (start),
    .pause      (pause),
    .clear      (clear),
    .load       (load),
    .load_val   (load_val),
    .count_down (count_down),
    .bcd_out    (bcd_out),
    .tick       (tick),
    .running    (running),
    .done       (done)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        st, pa, cl, ld, cd, ed;
    logic [15:0] lv;
    logic [15:0] eb;
    logic        er, edn;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, pa, cl, ld, cd, ed, input logic [15:0] lv, eb,
                     input logic er, edn);
    vec_t v;
    v.st = st; v.pa = pa; v.cl = cl; v.ld = ld; v.cd = cd; v.ed = ed;
    v.lv = lv; v.eb = eb; v.er = er; v.edn = edn;
    vecs.push_back(v);
  endtask

  // Optional slow_clk rise timed so its counting edge coincides with the controls.
  task automatic apply(input vec_t v, input int idx);
    string tag;
    @(negedge clk_in);
    if (v.ed) begin
      slow_clk = 1'b1;
      repeat (2) @(negedge clk_in);
    end
    start = v.st; pause = v.pa; clear = v.cl; load = v.ld;
    count_down = v.cd; load_val = v.lv;
    @(negedge clk_in);
    tag = $sformatf("vec%0d", idx);
    chk({tag, ".bcd"},     bcd_out,        v.eb);
    chk({tag, ".running"}, 16'(running),   16'(v.er));
    chk({tag, ".done"},    16'(done),      16'(v.edn));
    chk({tag, ".tick"},    16'(tick),      16'(v.ed));
    start = 1'b0; pause = 1'b0; clear = 1'b0; load = 1'b0;
    if (v.ed) begin
      slow_clk = 1'b0;
      repeat (3) @(negedge clk_in);
    end
  endtask

  initial begin
    int nticks;

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("reset.bcd",     bcd_out,        16'h0000);
    chk("reset.tick",    16'(tick),      16'h0);
    chk("reset.running", 16'(running),   16'h0);
    chk("reset.done",    16'(done),      16'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk_in);

    // Tick latency: high on the third rising edge only
    slow_clk = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk_in);
      chk($sformatf("latency.c%0d", i), 16'(tick), (i == 3) ? 16'h1 : 16'h0);
    end
    slow_clk = 1'b0;
    nticks = 0;
    repeat (6) begin
      @(negedge clk_in);
      if (tick) nticks++;
    end
    chk("fall_no_tick", 16'(nticks), 16'd0);

    nticks = 0;
    for (int p = 0; p < 5; p++) begin
      slow_clk = 1'b1;
      repeat (8) begin @(negedge clk_in); if (tick) nticks++; end
      slow_clk = 1'b0;
      repeat (8) begin @(negedge clk_in); if (tick) nticks++; end
    end
    chk("five_periods", 16'(nticks), 16'd5);
    chk("idle_no_count", bcd_out, 16'h0000);

    //  st pa cl ld cd ed  load_val  exp_bcd  run done
    add(0, 0, 0, 1, 0, 0, 16'h0958, 16'h0958, 0, 0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0958, 1, 0);
    add(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0959, 1, 0);
    add(0, 0, 0, 0, 0, 1, 16'h0000, 16'h1000, 1, 0);
    add(0, 0, 0, 0, 0, 1, 16'h0000, 16'h1001, 1, 0);
    add(0, 0, 0, 1, 0, 0, 16'hAB7C, 16'h1001, 1, 0);
    add(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    add(0, 0, 0, 1, 1, 0, 16'h0002, 16'h0002, 0, 0);
    add(1, 0, 0, 0, 1, 0, 16'h0000, 16'h0002, 1, 0);
    add(0, 0, 0, 0, 1, 1, 16'h0000, 16'h0001, 1, 0);
    add(0, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 1);
    add(0, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 0);
    add(1, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0);
    add(0, 0, 0, 1, 0, 0, 16'hAB7C, 16'h9959, 0, 0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h9959, 1, 0);
    add(0, 0, 0, 0, 0, 1, 16'h0000, 16'h9959, 0, 1);
    add(0, 0, 0, 0, 0, 1, 16'h0000, 16'h9959, 0, 0);
    add(0, 0, 1, 1, 0, 0, 16'h1234, 16'h0000, 0, 0);
    add(1, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1);
    add(0, 0, 0, 1, 0, 0, 16'h0010, 16'h0010, 0, 0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0010, 1, 0);
    add(0, 1, 0, 0, 0, 1, 16'h0000, 16'h0010, 0, 0);
    add(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0010, 0, 0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0010, 1, 0);
    add(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0011, 1, 0);
    add(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    add(1, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 1, 0);
    add(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0);
    add(0, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 1);
    add(0, 0, 0, 1, 1, 0, 16'h1000, 16'h1000, 0, 0);
    add(1, 0, 0, 0, 1, 0, 16'h0000, 16'h1000, 1, 0);
    add(0, 0, 0, 0, 1, 1, 16'h0000, 16'h0959, 1, 0);

    foreach (vecs[i]) apply(vecs[i], i);

    // Asynchronous reset while a tick is high and the timer is running
    @(negedge clk_in);
    slow_clk = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("pre_rst.tick", 16'(tick), 16'h1);
    chk("pre_rst.bcd",  bcd_out,   16'h0958);
    #1 rst = 1'b1;
    #1;
    chk("async_rst.bcd",     bcd_out,        16'h0000);
    chk("async_rst.tick",    16'(tick),      16'h0);
    chk("async_rst.running", 16'(running),   16'h0);
    chk("async_rst.done",    16'(done),      16'h0);
    @(negedge clk_in);
    slow_clk = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk_in);

    vecs.delete();
    add(1, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1);
    foreach (vecs[i]) apply(vecs[i], 100 + i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tick_bcd_timer.md
Name: tick_bcd_timer

Overview:
- Sits directly downstream of the slow clock divider.
- Brings the divider's slow square wave into the clk_in domain, turns each rising edge into a one-cycle tick, and drives a 4-digit BCD MM:SS timer. The timer counts up or down, with start/pause/clear/load control.
- Outputs feed the seven-segment display driver and the alarm/LED logic.

Parameters:
- MAX_MIN_TENS, 9, maximum minutes tens digit in up mode (up-mode ceiling is MAX_MIN_TENS9:59).
- SYNC_STAGES, 2, synchroniser flops on slow_clk (legal values 2..3).

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst  input  1  asynchronous, active-high reset
- slow_clk  input  1  divided clock from the divider; asynchronous to clk_in logic
- start  input  1  level-sampled each clk_in cycle; start/resume
- pause  input  1  pause while running
- clear  input  1  return to IDLE with count 00:00
- load  input  1  load load_val
- load_val  input  16  BCD {min_tens, min_ones, sec_tens, sec_ones}
- count_down  input  1  1 = decrement per tick, 0 = increment
- bcd_out  output  16  current count, same digit order as load_val
- tick  output  1  one clk_in-cycle pulse per slow_clk rising edge
- running  output  1  high in RUN state
- done  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (rst=1, asynchronous): bcd_out=16'h0000, tick=0, running=0, done=0, state=IDLE, and all synchroniser and edge flops=0.
- Synchroniser and tick:
  - slow_clk passes through SYNC_STAGES flops, then one history flop.
  - The edge condition is the last sync stage at 1 and the history flop at 0.
  - tick is registered from the edge condition. With SYNC_STAGES=2, tick is high for exactly one cycle, on the 3rd clk_in rising edge after slow_clk rises.
  - Falling edges of slow_clk produce no tick.
  - tick runs in every state; it is independent of the timer state.
- The count update uses the edge condition itself, so bcd_out changes on the same clk_in edge on which tick rises.
- States: IDLE, RUN, PAUSED, DONE; 2-bit encoding. running = (state==RUN).
- Control priority when inputs are asserted together: clear > load > start > pause > edge.
- Transitions:
  - clear, any state: go to IDLE, bcd_out=0000.
  - load in IDLE, PAUSED or DONE: bcd_out=sanitised load_val, go to IDLE. load in RUN is ignored.
  - IDLE + start: go to RUN. If count_down=1 and bcd_out=0000, go straight to DONE with a done pulse.
  - RUN + pause: go to PAUSED.
  - PAUSED + start: go to RUN.
  - DONE: holds until clear or load; start and pause are ignored.
  - RUN + edge: count by one step in the direction of count_down, sampled on that cycle.
  - Edge in any other state: bcd_out unchanged.
  - A control input in the same cycle as an edge wins; the edge is discarded for counting. Example: start in IDLE with an edge gives RUN with no count.
- Sanitising on load:
  - Any digit above 9 is forced to 9.
  - sec_tens above 5 is forced to 5.
  - min_tens above MAX_MIN_TENS is forced to MAX_MIN_TENS.
- Up count:
  - sec_ones 9 wraps to 0 and carries into sec_tens.
  - sec_tens 5 with a carry wraps to 0 and carries into min_ones.
  - min_ones 9 with a carry wraps to 0 and carries into min_tens.
  - Reaching MAX_MIN_TENS9:59 after the increment: go to DONE, done=1 for one cycle, and the value holds.
- Down count uses the mirror-image borrow rules (sec_ones 0 becomes 9, sec_tens 0 becomes 5, and so on).
  - Reaching 00:00 after the decrement: go to DONE with a done pulse.
  - A decrement is never applied at 0000, so there is no wrap to 99:59.
- count_down changing mid-RUN takes effect on the next edge.
- done is a single-cycle pulse and never re-asserts while the block stays in DONE.
- Reset mid-operation: all state is lost immediately and asynchronously. The first tick after reset release needs a fresh slow_clk rising edge, because the flops are cleared to 0.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Tick latency: rst pulse, then slow_clk held high at t0. Required: tick=1 for exactly one cycle on the 3rd clk_in edge. slow_clk falls with no tick. 5 slow_clk periods give exactly 5 ticks.
- Up count and carry: load_val=16'h0958, count_down=0, load then start, 3 edges. Required: bcd_out goes 0959, then 1000, then 1001, with running=1 throughout.
- Down to done: load_val=16'h0002, count_down=1, start, 2 edges. Required: bcd_out goes 0001, then 0000. done pulses exactly once, state=DONE, running=0. A further edge leaves bcd_out at 0000 with no done pulse.
- Pause, resume, priority: in RUN at 0010 up mode, assert pause in the same cycle as an edge. Required: PAUSED, bcd_out stays 0010. Edges while PAUSED give no change. start brings back RUN, and the next edge gives 0011.
- Sanitising and ignored load: load_val=16'hAB7C in IDLE gives bcd_out=9959. load asserted in RUN leaves bcd_out unchanged. clear together with load gives bcd_out=0000 and IDLE.
- Edge cases:
  - Start at zero in down mode: count_down=1, bcd_out=0000, start gives immediate DONE with a done pulse.
  - Up-mode ceiling: load 9959, up mode, one edge gives DONE. bcd_out holds 9959 (already at MAX_MIN_TENS9:59), done pulses once.
  - Reset mid-RUN: asserting rst asynchronously forces all outputs to 0 before the next clk_in edge.
